// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX frame generator.
// Holds FSM states, header/field widths and the frame byte mux.
package eth_pkg;

  localparam int HDR_LEN = 14;
  localparam int MAC_W   = 48;
  localparam int LEN_W   = 16;
  // One extra bit so 13 + 16'hFFFF never wraps.
  localparam int IDX_W   = LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  // Byte at frame index idx: header fields MSB first,
  // then payload counting up from seed.
  function automatic logic [7:0] frame_byte(
    input logic [IDX_W-1:0] idx,
    input logic [MAC_W-1:0] dst,
    input logic [MAC_W-1:0] src,
    input logic [LEN_W-1:0] len,
    input logic [7:0]       seed
  );
    logic [7:0] b;
    b = 8'(idx - IDX_W'(HDR_LEN)) + seed;
    if (idx < IDX_W'(HDR_LEN)) begin
      unique case (idx[3:0])
        4'd0:    b = dst[47:40];
        4'd1:    b = dst[39:32];
        4'd2:    b = dst[31:24];
        4'd3:    b = dst[23:16];
        4'd4:    b = dst[15:8];
        4'd5:    b = dst[7:0];
        4'd6:    b = src[47:40];
        4'd7:    b = src[39:32];
        4'd8:    b = src[31:24];
        4'd9:    b = src[23:16];
        4'd10:   b = src[15:8];
        4'd11:   b = src[7:0];
        4'd12:   b = len[15:8];
        4'd13:   b = len[7:0];
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/tx_frame_gen_if.sv
// AXI-Stream byte channel from the frame generator to the MAC.
// master drives data/valid/last, slave drives ready.
interface tx_frame_gen_if;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/tx_byte_cnt.sv
// Frame byte index and last-byte compare.
// Ports: clk, rst, i_en (advance), i_clr, i_len; o_idx, o_last.
module tx_byte_cnt
  import eth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [LEN_W-1:0] i_len,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_last_idx;

  assign w_last_idx = IDX_W'(i_len)
                    + IDX_W'(HDR_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_idx <= '0;
    else if (i_en)
      r_idx <= r_idx + IDX_W'(1);
  end

  assign o_idx  = r_idx;
  assign o_last = (r_idx == w_last_idx);

endmodule

// File: rtl/tx_frame_gen.sv
// Ethernet frame generator: header, counting payload, IFG.
// Ports: clk, rst, start, payload_len, m_axis, busy, frames_sent.
module tx_frame_gen
  import eth_pkg::*;
#(
  parameter logic [MAC_W-1:0] DEST_MAC =
    48'hFF_FF_FF_FF_FF_FF,
  parameter logic [MAC_W-1:0] SRC_MAC =
    48'h02_00_00_00_00_01,
  parameter int IFG_CYCLES = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  tx_frame_gen_if.master   m_axis,
  output logic             busy,
  output logic [LEN_W-1:0] frames_sent
);

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]       r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_busy;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_frames_sent;
  logic [7:0]       r_gap_cnt;

  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic             w_fire;
  logic             w_gap_done;
  logic [7:0]       w_byte;
  logic [7:0]       w_tdata_nxt;
  logic             w_tvalid_nxt;
  logic             w_tlast_nxt;
  logic             w_cnt_en;
  logic             w_cnt_clr;
  logic             w_len_ld;
  logic             w_sent_inc;

  // w_idx is the index of the next byte to load into
  // the output register, not the byte on the bus.
  tx_byte_cnt u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_cnt_en),
    .i_clr  (w_cnt_clr),
    .i_len  (r_len),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  assign w_fire     = r_tvalid & m_axis.m_axis_tready;
  assign w_gap_done = (r_gap_cnt == 8'(IFG_CYCLES - 1));
  assign w_byte     = frame_byte(w_idx, DEST_MAC, SRC_MAC,
                                 r_len, r_frames_sent[7:0]);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (start) w_state_nxt = ST_HEADER;
      ST_HEADER:
        if (w_fire && r_tlast)
          w_state_nxt = ST_GAP;
        // Byte 13 is on the bus once index 14 is next.
        else if (w_fire && w_idx == IDX_W'(HDR_LEN))
          w_state_nxt = ST_PAYLOAD;
      ST_PAYLOAD:
        if (w_fire && r_tlast) w_state_nxt = ST_GAP;
      ST_GAP:
        if (w_gap_done) w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_cnt_en     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_len_ld     = 1'b0;
    w_sent_inc   = 1'b0;
    unique case (r_state)
      ST_IDLE:
        if (start) begin
          w_len_ld     = 1'b1;
          w_cnt_en     = 1'b1;
          w_tdata_nxt  = w_byte;
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = 1'b0;
        end
      ST_HEADER, ST_PAYLOAD:
        if (w_fire) begin
          if (r_tlast) begin
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_cnt_clr    = 1'b1;
            w_sent_inc   = 1'b1;
          end else begin
            w_tdata_nxt  = w_byte;
            w_tlast_nxt  = w_last;
            w_cnt_en     = 1'b1;
          end
        end
      ST_GAP: begin
        w_cnt_clr    = 1'b1;
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
      end
      default: begin
        w_cnt_clr    = 1'b1;
        w_tvalid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_busy        <= 1'b0;
      r_len         <= '0;
      r_frames_sent <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_len_ld)
        r_len <= payload_len;
      if (w_sent_inc)
        r_frames_sent <= r_frames_sent + LEN_W'(1);
      if (r_state == ST_GAP)
        r_gap_cnt <= r_gap_cnt + 8'd1;
      else
        r_gap_cnt <= '0;
    end
  end

  assign m_axis.m_axis_tdata  = r_tdata;
  assign m_axis.m_axis_tvalid = r_tvalid;
  assign m_axis.m_axis_tlast  = r_tlast;
  assign busy                 = r_busy;
  assign frames_sent          = r_frames_sent;

endmodule

// File: tb/tb_tx_frame_gen.sv
// Directed bench for tx_frame_gen: frame table plus
// stall, back-to-back, abort and counter-wrap sequences.
module tb_tx_frame_gen;

  localparam logic [47:0] TB_SRC = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] payload_len = 16'd0;
  logic        tready = 1'b1;
  logic        busy;
  logic [15:0] frames_sent;

  tx_frame_gen_if axis();
  assign axis.m_axis_tready = tready;

  tx_frame_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .payload_len (payload_len),
    .m_axis      (axis),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] q_data[$];
  logic       q_last[$];
  int         gaps[$];

  typedef struct {
    logic [15:0] len;
    bit          stall;
    logic [7:0]  seed;
    int          exp_n;
    logic [7:0]  exp_last;
    logic [15:0] exp_sent;
  } vec_t;

  vec_t vecs[6];

  logic [7:0] exp32[18];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(
    input int k,
    input logic [15:0] len,
    input logic [7:0] seed
  );
    if (k < 6) return 8'hFF;
    if (k < 12) return 8'(TB_SRC >> (8 * (11 - k)));
    if (k == 12) return len[15:8];
    if (k == 13) return len[7:0];
    return 8'(k - 14) + seed;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(axis.m_axis_tlast), 32'd0);
    chk("rst_tdata", 32'(axis.m_axis_tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sent", 32'(frames_sent), 32'd0);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] len,
                            input bit stall,
                            input logic [7:0] seed,
                            input logic [15:0] exp_sent);
    int cyc;
    int nq;
    int gap_ok;
    bit done;
    bit held;
    logic [7:0] pd;
    logic pl;
    q_data.delete();
    q_last.delete();
    @(negedge clk);
    start = 1'b1;
    payload_len = len;
    tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    payload_len = ~len;
    chk("first_valid", 32'(axis.m_axis_tvalid), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
    cyc = 0;
    done = 0;
    held = 0;
    pd = '0;
    pl = 1'b0;
    while (!done && cyc < 2000) begin
      if (held)
        chk("stall_hold",
            32'({axis.m_axis_tvalid, axis.m_axis_tlast,
                 axis.m_axis_tdata}),
            32'({1'b1, pl, pd}));
      tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      held = axis.m_axis_tvalid && !tready;
      pd = axis.m_axis_tdata;
      pl = axis.m_axis_tlast;
      if (axis.m_axis_tvalid && tready) begin
        q_data.push_back(axis.m_axis_tdata);
        q_last.push_back(axis.m_axis_tlast);
        if (axis.m_axis_tlast) done = 1;
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    chk("frame_done", 32'(done), 32'd1);
    nq = q_data.size();
    chk("n_bytes", 32'(nq), 32'(14 + int'(len)));
    for (int i = 0; i < nq; i++) begin
      chk($sformatf("byte[%0d]", i), 32'(q_data[i]),
          32'(exp_byte(i, len, seed)));
      chk($sformatf("tlast[%0d]", i), 32'(q_last[i]),
          32'(i == nq - 1));
    end
    tready = 1'b1;
    gap_ok = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!axis.m_axis_tvalid && busy) gap_ok++;
    end
    chk("gap_cycles", 32'(gap_ok), 32'd12);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("sent", 32'(frames_sent), 32'(exp_sent));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ntx;
    int frames;
    int low;

    vecs[0] = '{16'd4,   1'b0, 8'h00, 18,  8'h03, 16'd1};
    vecs[1] = '{16'd0,   1'b0, 8'h01, 14,  8'h00, 16'd2};
    vecs[2] = '{16'd10,  1'b1, 8'h02, 24,  8'h0B, 16'd3};
    vecs[3] = '{16'd10,  1'b0, 8'h03, 24,  8'h0C, 16'd4};
    vecs[4] = '{16'd1,   1'b1, 8'h04, 15,  8'h04, 16'd5};
    vecs[5] = '{16'd300, 1'b0, 8'h05, 314, 8'h30, 16'd6};

    exp32 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
              8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03};

    do_reset();

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].len, vecs[v].stall,
                 vecs[v].seed, vecs[v].exp_sent);
      chk($sformatf("vec%0d_n", v), 32'(q_data.size()),
          32'(vecs[v].exp_n));
      if (q_data.size() > 0)
        chk($sformatf("vec%0d_last", v), 32'(q_data[$]),
            32'(vecs[v].exp_last));
      if (v == 0 && q_data.size() == 18)
        for (int i = 0; i < 18; i++)
          chk($sformatf("lit[%0d]", i), 32'(q_data[i]),
              32'(exp32[i]));
    end

    // Abort mid-payload with reset.
    do_reset();
    @(negedge clk);
    start = 1'b1;
    payload_len = 16'd10;
    tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    ntx = 0;
    while (cyc < 100 && !(axis.m_axis_tvalid && ntx == 19)) begin
      if (axis.m_axis_tvalid) ntx++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach", 32'(ntx), 32'd19);
    chk("abort_byte", 32'(axis.m_axis_tdata), 32'h05);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
    chk("abort_tlast", 32'(axis.m_axis_tlast), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sent", 32'(frames_sent), 32'd0);
    send_frame(16'd3, 1'b0, 8'h00, 16'd1);

    // Back-to-back frames with start held high.
    do_reset();
    q_data.delete();
    gaps.delete();
    frames = 0;
    low = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    payload_len = 16'd2;
    tready = 1'b1;
    while (frames < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (axis.m_axis_tvalid) begin
        if (low > 0) begin
          gaps.push_back(low);
          low = 0;
        end
        q_data.push_back(axis.m_axis_tdata);
        if (axis.m_axis_tlast) begin
          frames++;
          if (frames == 3) start = 1'b0;
        end
      end else if (frames > 0) begin
        low++;
      end
    end
    start = 1'b0;
    chk("b2b_frames", 32'(frames), 32'd3);
    chk("b2b_bytes", 32'(q_data.size()), 32'd48);
    chk("b2b_ngaps", 32'(gaps.size()), 32'd2);
    if (gaps.size() == 2) begin
      chk("b2b_gap0", 32'(gaps[0]), 32'd13);
      chk("b2b_gap1", 32'(gaps[1]), 32'd13);
    end
    if (q_data.size() == 48) begin
      chk("b2b_f1p0", 32'(q_data[14]), 32'h00);
      chk("b2b_f1p1", 32'(q_data[15]), 32'h01);
      chk("b2b_f2p0", 32'(q_data[30]), 32'h01);
      chk("b2b_f2p1", 32'(q_data[31]), 32'h02);
      chk("b2b_f3p0", 32'(q_data[46]), 32'h02);
      chk("b2b_f3p1", 32'(q_data[47]), 32'h03);
    end
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_sent", 32'(frames_sent), 32'd3);

    // Counter wrap: preload the count to its top value.
    @(negedge clk);
    force dut.r_frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.r_frames_sent;
    @(negedge clk);
    chk("preload", 32'(frames_sent), 32'hFFFF);
    send_frame(16'd2, 1'b0, 8'hFF, 16'd0);
    if (q_data.size() == 16) begin
      chk("wrap_p0", 32'(q_data[14]), 32'hFF);
      chk("wrap_p1", 32'(q_data[15]), 32'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
